// File: rtl/mmio_port_responder.sv
// mmio_port_responder: memory-mapped target for an external input port and a
// registered output port. Four-word window: OUT, IN, STATUS (W1C), CTRL.
// The input port is double-synchronized and captured on change while enabled.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          IN_WIDTH  = 8,
  parameter int          OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  output logic [31:0]          ReadData,
  output logic                 Hit,
  input  logic [IN_WIDTH-1:0]  PortIn,
  output logic [OUT_WIDTH-1:0] PortOut,
  output logic                 DataReady
);

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  logic [OUT_WIDTH-1:0] out_r;
  logic [IN_WIDTH-1:0]  sync1_r;
  logic [IN_WIDTH-1:0]  sync2_r;
  logic [IN_WIDTH-1:0]  last_r;
  logic [IN_WIDTH-1:0]  in_r;
  logic                 new_r;
  logic                 ovr_r;
  logic                 en_r;

  logic [1:0] offset_s;
  logic       wr_s;
  logic       change_s;
  logic       capture_s;
  logic       new_clear_s;
  logic       ovr_clear_s;
  logic       new_next_s;
  logic       ovr_next_s;
  logic       unused_addr_lsb;

  // Byte-lane bits of the address play no part in decode.
  assign unused_addr_lsb = ^Address[1:0];

  assign Hit       = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset_s  = Address[3:2];
  assign wr_s      = Hit && MemWrite;
  assign change_s  = (sync2_r != last_r);
  assign capture_s = change_s && en_r;

  // A load of IN consumes the data; a W1C store may clear either flag.
  assign new_clear_s = (Hit && MemRead && (offset_s == OFF_IN)) ||
                       (wr_s && (offset_s == OFF_STATUS) && WriteData[0]);
  assign ovr_clear_s = wr_s && (offset_s == OFF_STATUS) && WriteData[1];

  // Flag next-state: capture beats any clear; overrun only when unconsumed data is overwritten.
  always_comb begin
    new_next_s = new_r;
    ovr_next_s = ovr_r;
    if (capture_s) begin
      new_next_s = 1'b1;
      if (new_r && !new_clear_s) begin
        ovr_next_s = 1'b1;
      end else if (ovr_clear_s) begin
        ovr_next_s = 1'b0;
      end else begin
        ovr_next_s = ovr_r;
      end
    end else begin
      if (new_clear_s) begin
        new_next_s = 1'b0;
      end else begin
        new_next_s = new_r;
      end
      if (ovr_clear_s) begin
        ovr_next_s = 1'b0;
      end else begin
        ovr_next_s = ovr_r;
      end
    end
  end

  // Combinational load data; zero whenever the access is not a hitting load.
  always_comb begin
    ReadData = 32'h0000_0000;
    if (Hit && MemRead) begin
      case (offset_s)
        OFF_OUT:    ReadData = 32'(out_r);
        OFF_IN:     ReadData = 32'(in_r);
        OFF_STATUS: ReadData = {30'b0, ovr_r, new_r};
        OFF_CTRL:   ReadData = {31'b0, en_r};
        default:    ReadData = 32'h0000_0000;
      endcase
    end else begin
      ReadData = 32'h0000_0000;
    end
  end

  // Bus-writable registers: OUT and CTRL.EN.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= '0;
      en_r  <= 1'b1;
    end else begin
      if (wr_s && (offset_s == OFF_OUT)) begin
        out_r <= WriteData[OUT_WIDTH-1:0];
      end
      if (wr_s && (offset_s == OFF_CTRL)) begin
        en_r <= WriteData[0];
      end
    end
  end

  // Input synchronizer, change tracker (runs regardless of EN), capture register and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
      last_r  <= '0;
      in_r    <= '0;
      new_r   <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      sync1_r <= PortIn;
      sync2_r <= sync1_r;
      last_r  <= sync2_r;
      if (capture_s) begin
        in_r <= sync2_r;
      end
      new_r <= new_next_s;
      ovr_r <= ovr_next_s;
    end
  end

  assign PortOut   = out_r;
  assign DataReady = new_r;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder with a read-data scoreboard queue.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        DataReady;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  mmio_port_responder #(
    .BASE_ADDR(BASE),
    .IN_WIDTH (8),
    .OUT_WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData),
    .Hit      (Hit),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .DataReady(DataReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    Address   = 32'h0000_0000;
    WriteData = 32'h0000_0000;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a load, score the combinational data, then let the edge (and any side effect) happen.
  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    Address  = addr;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check(tag, ReadData, e);
    step();
    bus_idle();
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus_idle();
    PortIn = 8'h00;
    reset  = 1'b1;
    wait_cycles(2);
    reset = 1'b0;

    // Reset state
    check("rst_portout", PortOut, 32'h0);
    check("rst_dataready", {31'b0, DataReady}, 32'h0);
    read_chk("rst_status", BASE + 32'd8, 32'h0);
    read_chk("rst_ctrl", BASE + 32'd12, 32'h1);
    read_chk("rst_in", BASE + 32'd4, 32'h0);

    // OUT store and aligned/misaligned loads
    Address = BASE; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1;
    #1;
    check("out_before_edge", PortOut, 32'h0);
    step();
    bus_idle();
    check("out_portout", PortOut, 32'hDEAD_BEEF);
    read_chk("out_read", BASE, 32'hDEAD_BEEF);
    read_chk("out_read_misaligned", BASE + 32'd3, 32'hDEAD_BEEF);

    // Simultaneous load and store: load sees the old value
    Address = BASE; WriteData = 32'hCAFE_F00D; MemWrite = 1'b1; MemRead = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    check("rw_same_cycle_read", ReadData, exp_q.pop_front());
    step();
    bus_idle();
    check("rw_same_cycle_portout", PortOut, 32'hCAFE_F00D);

    // Capture latency: change driven after edge 0, visible after edge 3
    PortIn = 8'h5A;
    step();
    check("lat_e1", {31'b0, DataReady}, 32'h0);
    step();
    check("lat_e2", {31'b0, DataReady}, 32'h0);
    step();
    check("lat_e3", {31'b0, DataReady}, 32'h1);
    read_chk("in_5a", BASE + 32'd4, 32'h0000_005A);
    check("read_clears_new", {31'b0, DataReady}, 32'h0);

    // Two captures with no read: overrun, then W1C OVR, then read clears NEW
    PortIn = 8'h11;
    wait_cycles(4);
    PortIn = 8'h22;
    wait_cycles(4);
    read_chk("status_ovr", BASE + 32'd8, 32'h3);
    write(BASE + 32'd8, 32'h2);
    read_chk("status_w1c_ovr", BASE + 32'd8, 32'h1);
    read_chk("in_22", BASE + 32'd4, 32'h0000_0022);
    read_chk("status_cleared", BASE + 32'd8, 32'h0);

    // Capture disabled, re-enable without spurious capture, then a real change
    write(BASE + 32'd12, 32'h0);
    read_chk("ctrl_off", BASE + 32'd12, 32'h0);
    PortIn = 8'hFF;
    wait_cycles(4);
    check("dis_no_new", {31'b0, DataReady}, 32'h0);
    read_chk("dis_status", BASE + 32'd8, 32'h0);
    read_chk("dis_in_unchanged", BASE + 32'd4, 32'h0000_0022);
    write(BASE + 32'd12, 32'h1);
    wait_cycles(4);
    check("reen_no_spurious", {31'b0, DataReady}, 32'h0);
    PortIn = 8'h0F;
    wait_cycles(4);
    check("reen_capture", {31'b0, DataReady}, 32'h1);
    read_chk("in_0f", BASE + 32'd4, 32'h0000_000F);

    // Capture edge coincides with a load of IN
    PortIn = 8'h33;
    wait_cycles(2);
    read_chk("coincide_old_in", BASE + 32'd4, 32'h0000_000F);
    check("coincide_new", {31'b0, DataReady}, 32'h1);
    read_chk("coincide_status", BASE + 32'd8, 32'h1);
    read_chk("in_33", BASE + 32'd4, 32'h0000_0033);

    // Reset beats a same-cycle store
    Address = BASE; WriteData = 32'h1234_5678; MemWrite = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    bus_idle();
    check("reset_wins_portout", PortOut, 32'h0);
    read_chk("reset_ctrl", BASE + 32'd12, 32'h1);
    read_chk("reset_in", BASE + 32'd4, 32'h0);

    // Out-of-window access
    Address = BASE + 32'd16; WriteData = 32'hFFFF_FFFF; MemWrite = 1'b1; MemRead = 1'b1;
    exp_q.push_back(32'h0);
    #1;
    check("miss_hit", {31'b0, Hit}, 32'h0);
    check("miss_readdata", ReadData, exp_q.pop_front());
    step();
    bus_idle();
    check("miss_portout", PortOut, 32'h0);
    Address = BASE + 32'd12;
    #1;
    check("edge_hit", {31'b0, Hit}, 32'h1);
    bus_idle();
    read_chk("miss_ctrl", BASE + 32'd12, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
